// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchronizer, oversampling tick generator, framing FSM and valid/ready output register.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
    parameter int NATIVE_CLK_FREQUENCY = 1000000000,
    parameter int BAUDRATE             = 9600,
    parameter int FRAME_DATA_LENGTH    = 8,
    parameter int BIG_ENDIAN           = 0,
    parameter int OVERSAMPLE           = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD           = 0
`endif
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         rx,
    output logic [FRAME_DATA_LENGTH-1:0] data,
    output logic                         valid,
    input  logic                         ready,
    output logic                         frame_error,
    output logic                         overrun,
`ifdef UART_RX_PARITY_EN
    output logic                         parity_error,
`endif
    output logic                         busy
);

    localparam int DIV   = NATIVE_CLK_FREQUENCY / (BAUDRATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = (FRAME_DATA_LENGTH > 1) ? $clog2(FRAME_DATA_LENGTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  HALF_LAST = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  FULL_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(FRAME_DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t                         state;
    logic                           rx_meta;
    logic                           rx_s;
    logic                           rx_prev;
    logic [DIV_W-1:0]               div_cnt;
    logic [SC_W-1:0]                sample_cnt;
    logic [BC_W-1:0]                bit_cnt;
    logic [FRAME_DATA_LENGTH-1:0]   shift_reg;
    logic [FRAME_DATA_LENGTH-1:0]   shift_next;
    logic                           tick;
    logic                           start_detect;
    logic                           bit_sample;
    logic                           good_frame;
    logic                           parity_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign start_detect = (state == IDLE) && rx_prev && !rx_s;

    // Restarting the divider on the start edge keeps every sample point a fixed offset from that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (start_detect || (div_cnt == DIV_LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick       = (div_cnt == DIV_LAST);
    assign bit_sample = tick && (sample_cnt == FULL_LAST);

    generate
        if (FRAME_DATA_LENGTH == 1) begin : g_shift_single
            assign shift_next = rx_s;
        end else if (BIG_ENDIAN != 0) begin : g_shift_msb_first
            assign shift_next = {shift_reg[FRAME_DATA_LENGTH-2:0], rx_s};
        end else begin : g_shift_lsb_first
            assign shift_next = {rx_s, shift_reg[FRAME_DATA_LENGTH-1:1]};
        end
    endgenerate

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    assign parity_bad = (^shift_reg) ^ parity_bit ^ (PARITY_ODD != 0);
`else
    assign parity_bad = 1'b0;
`endif

    assign good_frame = (state == STOP) && bit_sample && rx_s && !parity_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data        <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit   <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
`endif
            if (valid && ready) begin
                valid <= 1'b0;
            end
            // A handshake in the same cycle frees the register, so the new word is not an overrun.
            if (good_frame) begin
                if (!valid || ready) begin
                    data  <= shift_reg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start_detect) begin
                        state      <= START;
                        sample_cnt <= '0;
                        bit_cnt    <= '0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_cnt == HALF_LAST) begin
                            sample_cnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (sample_cnt == FULL_LAST) begin
                            sample_cnt <= '0;
                            shift_reg  <= shift_next;
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= PARITY;
`else
                                state   <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (sample_cnt == FULL_LAST) begin
                            sample_cnt <= '0;
                            parity_bit <= rx_s;
                            state      <= STOP;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (sample_cnt == FULL_LAST) begin
                            sample_cnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                if (parity_bad) begin
                                    parity_error <= 1'b1;
                                end
`endif
                            end else begin
                                frame_error <= 1'b1;
                                state       <= BREAK;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                // A line held low after a bad stop bit must rise before another start edge counts.
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: an LSB-first instance covers most scenarios and an MSB-first instance covers bit order.
module tb_uart_receiver;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_le = 1'b1;
    logic       rx_be = 1'b1;
    logic       ready_le = 1'b1;
    logic       ready_be = 1'b1;
    logic [7:0] data_le, data_be;
    logic       valid_le, valid_be;
    logic       fe_le, fe_be;
    logic       ovr_le, ovr_be;
    logic       busy_le, busy_be;
`ifdef UART_RX_PARITY_EN
    logic       pe_le, pe_be;
`endif

    logic [7:0] exp_le_q[$];
    logic [7:0] exp_be_q[$];

    int n_compared = 0;
    int n_mismatched = 0;
    int valid_cyc = 0;
    int fe_cnt = 0;
    int ovr_cnt = 0;
    int be_err_cnt = 0;
    int v0, f0, o0;

    always #5 clk = ~clk;

    uart_receiver #(
        .NATIVE_CLK_FREQUENCY(1600000),
        .BAUDRATE(10000),
        .FRAME_DATA_LENGTH(8),
        .BIG_ENDIAN(0),
        .OVERSAMPLE(16)
    ) dut_le (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx_le),
        .data(data_le),
        .valid(valid_le),
        .ready(ready_le),
        .frame_error(fe_le),
        .overrun(ovr_le),
`ifdef UART_RX_PARITY_EN
        .parity_error(pe_le),
`endif
        .busy(busy_le)
    );

    uart_receiver #(
        .NATIVE_CLK_FREQUENCY(1600000),
        .BAUDRATE(10000),
        .FRAME_DATA_LENGTH(8),
        .BIG_ENDIAN(1),
        .OVERSAMPLE(16)
    ) dut_be (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx_be),
        .data(data_be),
        .valid(valid_be),
        .ready(ready_be),
        .frame_error(fe_be),
        .overrun(ovr_be),
`ifdef UART_RX_PARITY_EN
        .parity_error(pe_be),
`endif
        .busy(busy_be)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (valid_le) valid_cyc++;
            if (fe_le) fe_cnt++;
            if (ovr_le) ovr_cnt++;
            if (fe_be || ovr_be) be_err_cnt++;
            if (valid_le && ready_le) begin
                if (exp_le_q.size() == 0) begin
                    check("le_spurious_valid", 32'(valid_le), 32'h0);
                end else begin
                    logic [7:0] e;
                    e = exp_le_q.pop_front();
                    $display("le word 0x%02h expected 0x%02h", data_le, e);
                    check("le_data", 32'(data_le), 32'(e));
                end
            end
            if (valid_be && ready_be) begin
                if (exp_be_q.size() == 0) begin
                    check("be_spurious_valid", 32'(valid_be), 32'h0);
                end else begin
                    logic [7:0] e;
                    e = exp_be_q.pop_front();
                    $display("be word 0x%02h expected 0x%02h", data_be, e);
                    check("be_data", 32'(data_be), 32'(e));
                end
            end
        end
    end

    task automatic drive(input bit be_line, input logic v);
        if (be_line) rx_be = v;
        else rx_le = v;
    endtask

    task automatic wait_bits(input int n);
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    // Wire order is always val[0] first; the line is left at the stop level on return.
    task automatic send_frame(input bit be_line, input logic [7:0] val, input logic stop_val, input int nstop);
        drive(be_line, 1'b0);
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            drive(be_line, val[i]);
            wait_bits(1);
        end
        for (int s = 0; s < nstop; s++) begin
            drive(be_line, stop_val);
            wait_bits(1);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_le_q.size() != 0 || exp_be_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_le_q.size() + exp_be_q.size()), 32'h0);
    endtask

    task automatic snap();
        v0 = valid_cyc;
        f0 = fe_cnt;
        o0 = ovr_cnt;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("reset_data", 32'(data_le), 32'h0);
        check("reset_valid", 32'(valid_le), 32'h0);
        check("reset_frame_error", 32'(fe_le), 32'h0);
        check("reset_overrun", 32'(ovr_le), 32'h0);
        check("reset_busy", 32'(busy_le), 32'h0);
        reset_n = 1'b1;
        wait_bits(1);

        // Single frame
        snap();
        exp_le_q.push_back(8'hA5);
        send_frame(1'b0, 8'hA5, 1'b1, 1);
        drain("single_drain", 400);
        wait_bits(1);
        check("single_valid_cycles", 32'(valid_cyc - v0), 32'd1);
        check("single_frame_error", 32'(fe_cnt - f0), 32'd0);
        check("single_overrun", 32'(ovr_cnt - o0), 32'd0);

        // MSB-first: wire bits 1,0,1,1,0,0,0,1
        exp_be_q.push_back(8'hB1);
        send_frame(1'b1, 8'h8D, 1'b1, 1);
        drain("be_drain", 400);
        wait_bits(1);
        check("be_busy_idle", 32'(busy_be), 32'h0);

        // Glitch shorter than half a bit
        snap();
        rx_le = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_busy_started", 32'(busy_le), 32'h1);
        repeat (20) @(negedge clk);
        rx_le = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_busy_end", 32'(busy_le), 32'h0);
        check("glitch_valid", 32'(valid_cyc - v0), 32'd0);
        check("glitch_frame_error", 32'(fe_cnt - f0), 32'd0);

        // Bad stop bit, line held low for 5 bit times
        snap();
        send_frame(1'b0, 8'h3C, 1'b0, 1);
        wait_bits(4);
        check("break_busy_low", 32'(busy_le), 32'h1);
        check("break_frame_error", 32'(fe_cnt - f0), 32'd1);
        rx_le = 1'b1;
        wait_bits(2);
        check("break_busy_released", 32'(busy_le), 32'h0);
        check("break_valid", 32'(valid_cyc - v0), 32'd0);
        exp_le_q.push_back(8'h55);
        send_frame(1'b0, 8'h55, 1'b1, 1);
        drain("after_break_drain", 400);
        wait_bits(1);
        check("after_break_frame_error", 32'(fe_cnt - f0), 32'd1);

        // Overrun with consumer stalled
        snap();
        ready_le = 1'b0;
        exp_le_q.push_back(8'h11);
        send_frame(1'b0, 8'h11, 1'b1, 2);
        send_frame(1'b0, 8'h22, 1'b1, 2);
        check("overrun_valid_held", 32'(valid_le), 32'h1);
        check("overrun_data_held", 32'(data_le), 32'h11);
        check("overrun_pulses", 32'(ovr_cnt - o0), 32'd1);
        @(posedge clk);
        #1 ready_le = 1'b1;
        drain("overrun_drain", 50);
        @(negedge clk);
        check("overrun_valid_cleared", 32'(valid_le), 32'h0);

        // Reset during data bit 4 of 0xFF
        rx_le = 1'b0;
        wait_bits(1);
        rx_le = 1'b1;
        wait_bits(4);
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("midreset_busy_before", 32'(busy_le), 32'h1);
        reset_n = 1'b0;
        #1;
        check("midreset_data", 32'(data_le), 32'h0);
        check("midreset_valid", 32'(valid_le), 32'h0);
        check("midreset_busy", 32'(busy_le), 32'h0);
        check("midreset_frame_error", 32'(fe_le), 32'h0);
        check("midreset_overrun", 32'(ovr_le), 32'h0);
        repeat (20) @(negedge clk);
        reset_n = 1'b1;
        wait_bits(2);
        snap();
        exp_le_q.push_back(8'h0F);
        send_frame(1'b0, 8'h0F, 1'b1, 1);
        drain("midreset_drain", 400);
        wait_bits(1);
        check("midreset_valid_cycles", 32'(valid_cyc - v0), 32'd1);
        check("be_error_pulses", 32'(be_err_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Asynchronous serial receiver, the receive end of the team's UART transmitter.
- Oversamples the `rx` line, detects the start bit, centre-samples the data bits, checks the stop bit, and presents each frame as a parallel word with a valid/ready handshake.
- Sits between the board RX pin and the consumer logic, for example a FIFO or command decoder.
- Accepts frames of 1 start bit (0), FRAME_DATA_LENGTH data bits and 1 or more stop bits (1).

Parameters:
- NATIVE_CLK_FREQUENCY, 1000000000: `clk` frequency in Hz.
- BAUDRATE, 9600: line bit rate in bits/s.
- FRAME_DATA_LENGTH, 8: number of data bits per frame.
- BIG_ENDIAN, 0: 0 means the first data bit on the wire is the LSB; 1 means it is the MSB.
- OVERSAMPLE, 16: sample ticks per bit period; must be even and at least 4.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- rx, input, 1: serial line, idle high, asynchronous to `clk`.
- data, output, FRAME_DATA_LENGTH: received word, bit [0] is the LSB.
- valid, output, 1: `data` holds an unconsumed word.
- ready, input, 1: consumer accepts `data` when `valid` && `ready` at a rising edge of `clk`.
- frame_error, output, 1: one-cycle pulse when a stop bit samples 0.
- overrun, output, 1: one-cycle pulse when a good frame completes while `valid` is still 1.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Clock and reset:
  - Single clock `clk`; reset_n is asynchronous and active-low.
  - On reset: `data`=0, `valid`=0, `frame_error`=0, `overrun`=0, `busy`=0, state IDLE, tick and bit counters 0.
  - Synchronizer flops reset to 1.
- Input synchronization: `rx` passes through a 2-flop synchronizer, giving `rx_s`. All sampling uses `rx_s`.
- Tick generator:
  - DIV = NATIVE_CLK_FREQUENCY / (BAUDRATE*OVERSAMPLE), integer floor; DIV must be at least 1.
  - Counter 0..DIV-1 gives a one-`clk` tick each DIV cycles.
  - The counter is cleared on entry to START so sampling phase aligns to the detected edge.
- State machine (IDLE, START, DATA, STOP, BREAK):
  - IDLE: on `rx_s` 1->0 (previous sampled value 1), go to START and clear the tick and sample counters.
  - START: after OVERSAMPLE/2 ticks, sample `rx_s`. If 1, treat as a false start and return to IDLE with no output. If 0, go to DATA.
  - DATA: every OVERSAMPLE ticks, sample one bit into the shift register.
    - BIG_ENDIAN=0: the first bit lands in data[0].
    - BIG_ENDIAN=1: the first bit lands in data[FRAME_DATA_LENGTH-1].
    - After FRAME_DATA_LENGTH bits, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample `rx_s`.
    - If 1: the frame is good; return to IDLE.
    - If 0: pulse `frame_error` one cycle, discard the word, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- Output register:
  - On a good frame with `valid`=0: the cycle after the stop sample, load `data` and set `valid`=1.
  - On a good frame with `valid`=1: keep the old `data`, drop the new word, pulse `overrun` one cycle.
  - `valid` clears on the `clk` edge where `valid` && `ready`.
  - If the handshake and a new good frame land in the same cycle, the new word loads, `valid` stays 1, and no overrun is flagged.
  - `data` is stable while `valid`=1.
- Latency: `valid` rises 1 `clk` after the stop-bit sample point. The stop sample is about FRAME_DATA_LENGTH+1 bit periods after the start edge, plus 2 cycles of synchronizer delay.
- Multiple stop bits: extra stop bits are consumed in IDLE as idle line, so back-to-back frames with 1 or 2 stop bits are received without loss.
- Reset mid-frame: everything returns to reset values immediately, and a partial word is never output.

Optional Feature:
- UART_RX_PARITY_EN:
  - When defined: one parity bit is expected between the last data bit and the stop bit. Parameter PARITY_ODD (default 0, even parity) is added, along with output port `parity_error` (1-bit pulse).
  - On a parity mismatch with a good stop bit: pulse `parity_error`, discard the word, return to IDLE.
  - When not defined: no parity state, no port or parameter; the frame is start, data, stop only.

Test Plan:
- Single frame: NATIVE=1600000, BAUD=10000, OVERSAMPLE=16 (DIV=10, 160 clk/bit), BIG_ENDIAN=0. Drive 0xA5 LSB first with 1 stop bit, `ready`=1. Expect `valid` high for exactly 1 cycle with `data`=0xA5, and no error pulses.
- Endianness: same setup with BIG_ENDIAN=1, wire bits 1,0,1,1,0,0,0,1. Expect `data`=0xB1.
- Glitch: a low pulse of 40 clk (less than half a bit) on idle `rx`. Expect a return to IDLE, no `valid`, no `frame_error`.
- Framing: send 0x3C with the stop bit forced to 0 and the line held low for 5 bit times. Expect a single `frame_error` pulse, no `valid`, `busy` high until the line rises, then correct reception of a following 0x55.
- Overrun: hold `ready`=0 and send 0x11 then 0x22 back-to-back with 2 stop bits. Expect `data`=0x11 held, one `overrun` pulse, then `ready`=1 clears `valid`.
- Reset mid-frame: assert reset_n=0 during data bit 4 of 0xFF, release, then send 0x0F. Expect all outputs 0 during reset and a correct `data`=0x0F afterwards.
